// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate scheduler.
// Requester indices: entries occupy 0..1, exits occupy 2..3.
package parking_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] ENT0 = 2'd0;
    localparam logic [1:0] ENT1 = 2'd1;
    localparam logic [1:0] EXT0 = 2'd2;
    localparam logic [1:0] EXT1 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic is_entry(input logic [1:0] idx);
        return (idx == ENT0) || (idx == ENT1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
// The search starts at ptr and wraps; the first pending request wins.
module rr_arbiter4
    import parking_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx,
    output logic               vld
);

    logic [1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!vld && req[cand]) begin
                vld         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises entry/exit gate requests into single Parking transactions
// (IDLE -> ISSUE -> WAIT -> RESP) with round-robin fairness and a deny counter.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int RESP_WAIT = 1,
    parameter int DENY_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ent_req,
    input  logic [1:0]        ent_uni,
    input  logic [1:0]        ext_req,
    input  logic [1:0]        ext_uni,
    output logic [1:0]        ent_done,
    output logic [1:0]        ext_done,
    output logic [1:0]        ent_ok,
    output logic [1:0]        ext_ok,
    output logic              car_entered,
    output logic              is_uni_car_entered,
    output logic              car_exited,
    output logic              is_uni_car_exited,
    input  logic              is_vacated_space,
    input  logic              uni_is_vacated_space,
    input  logic              illegal_enter,
    input  logic              illegal_exit,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic [DENY_W-1:0] deny_cnt
);

    localparam logic [2:0] WAIT_LAST = 3'(RESP_WAIT - 1);

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [2:0]          wait_q, wait_d;
    logic [DENY_W-1:0]   deny_q, deny_d;
    logic                uni_q, uni_d;
    logic                result_q, result_d;

    logic [NUM_REQ-1:0]  req_vec;
    logic [NUM_REQ-1:0]  uni_vec;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [1:0]          arb_idx;
    logic                arb_vld;
    logic                win_uni;
    logic                win_vacancy;

    assign req_vec = {ext_req, ent_req};
    assign uni_vec = {ext_uni, ent_uni};

    rr_arbiter4 u_arb (
        .req   (req_vec),
        .ptr   (ptr_q),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .vld   (arb_vld)
    );

    assign win_uni     = |(arb_gnt & uni_vec);
    assign win_vacancy = win_uni ? uni_is_vacated_space : is_vacated_space;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        wait_d   = wait_q;
        deny_d   = deny_q;
        uni_d    = uni_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    ptr_d   = arb_idx + 2'd1;
                    uni_d   = win_uni;
                    // An entry with no space for its class is refused without touching Parking.
                    if (is_entry(arb_idx) && !win_vacancy) begin
                        result_d = 1'b0;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    result_d = is_entry(grant_q) ? !illegal_enter : !illegal_exit;
                    state_d  = S_RESP;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_RESP: begin
                if (!result_q && (deny_q != {DENY_W{1'b1}})) begin
                    deny_d = deny_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ent_done           = '0;
        ext_done           = '0;
        ent_ok             = '0;
        ext_ok             = '0;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        car_exited         = 1'b0;
        is_uni_car_exited  = 1'b0;
        if (state_q == S_ISSUE) begin
            car_entered        = is_entry(grant_q);
            is_uni_car_entered = is_entry(grant_q) && uni_q;
            car_exited         = !is_entry(grant_q);
            is_uni_car_exited  = !is_entry(grant_q) && uni_q;
        end
        if (state_q == S_RESP) begin
            if (is_entry(grant_q)) begin
                ent_done[grant_q[0]] = 1'b1;
                ent_ok[grant_q[0]]   = result_q;
            end else begin
                ext_done[grant_q[0]] = 1'b1;
                ext_ok[grant_q[0]]   = result_q;
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;
    assign deny_cnt = deny_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wait_q  <= '0;
            deny_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wait_q  <= wait_d;
            deny_q  <= deny_d;
        end
    end

    // Latched class and verdict are only consumed in ISSUE/RESP, so they carry no reset.
    always_ff @(posedge clk) begin
        uni_q    <= uni_d;
        result_q <= result_d;
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench for parking_gate_scheduler using a transaction-level
// reference model (round-robin scan, vacancy/illegal rules, saturating deny count).
module tb_parking_gate_scheduler;

    localparam int P_WAIT = 1;
    localparam int P_DW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      ent_req, ent_uni, ext_req, ext_uni;
    logic [1:0]      ent_done, ext_done, ent_ok, ext_ok;
    logic            car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic            is_vacated_space, uni_is_vacated_space, illegal_enter, illegal_exit;
    logic            busy;
    logic [1:0]      grant_id;
    logic [P_DW-1:0] deny_cnt;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;
    int model_deny = 0;

    always #5 clk = ~clk;

    parking_gate_scheduler #(.RESP_WAIT(P_WAIT), .DENY_W(P_DW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ent_req              (ent_req),
        .ent_uni              (ent_uni),
        .ext_req              (ext_req),
        .ext_uni              (ext_uni),
        .ent_done             (ent_done),
        .ext_done             (ext_done),
        .ent_ok               (ent_ok),
        .ext_ok               (ext_ok),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .is_vacated_space     (is_vacated_space),
        .uni_is_vacated_space (uni_is_vacated_space),
        .illegal_enter        (illegal_enter),
        .illegal_exit         (illegal_exit),
        .busy                 (busy),
        .grant_id             (grant_id),
        .deny_cnt             (deny_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: the winner is found by scanning from the model
    // pointer; illegal flags show the wrong value until the strobe cycle so only
    // the late sample counts.
    task automatic do_txn(input logic [3:0] rq, input logic [3:0] un, input bit vac,
                          input bit uvac, input bit ien, input bit iex,
                          input bit drop_mid, input string tag);
        int         w;
        bit         is_ent, denied, exp_ok;
        int         lat;
        logic [3:0] exp_str, exp_dn, obs_str, obs_dn, obs_ok;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (model_ptr + i) % 4;
            if (w < 0 && rq[j]) w = j;
        end
        is_ent = (w < 2);
        denied = is_ent && !(un[w] ? uvac : vac);
        exp_ok = denied ? 1'b0 : (is_ent ? !ien : !iex);
        lat    = denied ? 1 : 2 + P_WAIT;
        ent_req = rq[1:0]; ext_req = rq[3:2];
        ent_uni = un[1:0]; ext_uni = un[3:2];
        is_vacated_space = vac; uni_is_vacated_space = uvac;
        illegal_enter = !ien; illegal_exit = !iex;
        for (int c = 1; c <= lat; c++) begin
            step();
            exp_str = 4'b0000;
            if (!denied && c == 1)
                exp_str = is_ent ? {1'b1, un[w], 2'b00} : {2'b00, 1'b1, un[w]};
            obs_str = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
            checks++;
            if (obs_str !== exp_str) begin
                errors++;
                $display("FAIL %s strobes c=%0d got=%b exp=%b", tag, c, obs_str, exp_str);
            end
            checks++;
            if ({busy, grant_id} !== {1'b1, 2'(w)}) begin
                errors++;
                $display("FAIL %s busy/grant c=%0d got=%b/%0d exp=1/%0d", tag, c, busy, grant_id, w);
            end
            exp_dn = (c == lat) ? 4'(1 << w) : 4'b0000;
            obs_dn = {ext_done, ent_done};
            checks++;
            if (obs_dn !== exp_dn) begin
                errors++;
                $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, obs_dn, exp_dn);
            end
            if (c == lat) begin
                obs_ok = {ext_ok, ent_ok} & exp_dn;
                checks++;
                if (obs_ok !== (exp_ok ? exp_dn : 4'b0000)) begin
                    errors++;
                    $display("FAIL %s ok got=%b exp=%b", tag, obs_ok, exp_ok ? exp_dn : 4'b0000);
                end
            end
            if (c == 1) begin
                illegal_enter = ien; illegal_exit = iex;
                if (drop_mid) begin
                    ent_req = 2'b00; ext_req = 2'b00;
                    ent_uni = 2'($urandom); ext_uni = 2'($urandom);
                end
            end
        end
        rq[w] = 1'b0;
        if (!drop_mid) begin
            ent_req = rq[1:0]; ext_req = rq[3:2];
        end
        if (!exp_ok && model_deny < (1 << P_DW) - 1) model_deny++;
        model_ptr = (w + 1) % 4;
        step();
        checks++;
        if ({busy, ext_done, ent_done} !== 5'b0) begin
            errors++;
            $display("FAIL %s idle-after got busy=%b done=%b%b exp 0", tag, busy, ext_done, ent_done);
        end
        checks++;
        if (deny_cnt !== P_DW'(model_deny)) begin
            errors++;
            $display("FAIL %s deny_cnt got=%0d exp=%0d", tag, deny_cnt, model_deny);
        end
    endtask

    task automatic test_reset();
        ent_req = 0; ext_req = 0; ent_uni = 0; ext_uni = 0;
        is_vacated_space = 1; uni_is_vacated_space = 1;
        illegal_enter = 0; illegal_exit = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        model_ptr = 0; model_deny = 0;
        checks++;
        if ({busy, grant_id} !== 3'b000) begin
            errors++;
            $display("FAIL reset busy/grant got=%b/%0d exp=0/0", busy, grant_id);
        end
        checks++;
        if (deny_cnt !== '0) begin
            errors++;
            $display("FAIL reset deny_cnt got=%0d exp=0", deny_cnt);
        end
        checks++;
        if ({ent_done, ext_done, ent_ok, ext_ok, car_entered, is_uni_car_entered,
             car_exited, is_uni_car_exited} !== 12'b0) begin
            errors++;
            $display("FAIL reset outputs got=%b%b%b%b exp all 0", ent_done, ext_done, ent_ok, ext_ok);
        end
    endtask

    task automatic test_basic_entry();
        do_txn(4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "basic_entry");
    endtask

    task automatic test_vacancy_deny();
        do_txn(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "vacancy_deny");
        do_txn(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "uni_vacancy_deny");
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int n = 0; n < 5; n++)
            do_txn(4'hF, 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "back_to_back");
    endtask

    task automatic test_exit_illegal_saturation();
        do_txn(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "exit_illegal");
        for (int n = 0; n < 299; n++)
            do_txn(4'b0100, 4'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "exit_sat");
        checks++;
        if (deny_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturation deny_cnt got=%0d exp=255", deny_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            do_txn(4'($urandom_range(1, 15)), 4'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_reset_in_wait();
        test_reset();
        do_txn(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_abort");
        ent_req = 2'b01; ext_req = 2'b10; ent_uni = 0; ext_uni = 0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_ptr = 0; model_deny = 0;
        checks++;
        if ({busy, grant_id, ent_done, ext_done} !== 7'b0) begin
            errors++;
            $display("FAIL abort got busy=%b grant=%0d done=%b%b exp 0", busy, grant_id, ext_done, ent_done);
        end
        checks++;
        if (deny_cnt !== '0) begin
            errors++;
            $display("FAIL abort deny_cnt got=%0d exp=0", deny_cnt);
        end
        do_txn(4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_vacancy_deny();
        test_back_to_back();
        test_exit_illegal_saturation();
        test_random();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
